// File: rtl/fmrv32im_rd_arb.sv
// fmrv32im_rd_arb: two-requester (icache I / dcache D) read arbiter onto a
// single AXI4 master read channel. One burst in flight at a time; the grant
// register steers the R channel back to the winner.
// Optional feature: define FMRV32IM_RD_ARB_RR_EN for round-robin arbitration
// of simultaneous requests; otherwise D has fixed priority.
`timescale 1ns/1ps
module fmrv32im_rd_arb #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  // icache requester
  input  logic [ADDR_W-1:0] I_ARADDR,
  input  logic [7:0]        I_ARLEN,
  input  logic              I_ARVALID,
  output logic              I_ARREADY,
  output logic [31:0]       I_RDATA,
  output logic [1:0]        I_RRESP,
  output logic              I_RLAST,
  output logic              I_RVALID,
  input  logic              I_RREADY,
  // dcache requester
  input  logic [ADDR_W-1:0] D_ARADDR,
  input  logic [7:0]        D_ARLEN,
  input  logic              D_ARVALID,
  output logic              D_ARREADY,
  output logic [31:0]       D_RDATA,
  output logic [1:0]        D_RRESP,
  output logic              D_RLAST,
  output logic              D_RVALID,
  input  logic              D_RREADY,
  // AXI4 master read-address channel
  output logic              M_AXI_ARID,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  // AXI4 master read-data channel
  input  logic              M_AXI_RID,
  input  logic [31:0]       M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RLAST,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic              req_any;
  logic              win;
  logic              in_addr, in_data;

  // RID is deliberately ignored: routing relies on the grant register alone.
  logic unused_rid;
  assign unused_rid = M_AXI_RID;

`ifdef FMRV32IM_RD_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Winner select: pointer breaks ties, favouring the requester not granted last
  always_comb begin
    req_any = I_ARVALID | D_ARVALID;
    win     = (I_ARVALID & D_ARVALID) ? ptr_q : D_ARVALID;
    ptr_d   = ptr_q;
    if (state_q == S_IDLE && req_any) ptr_d = ~win;
  end

  // Round-robin pointer register
  always_ff @(posedge CLK) begin
    if (RST) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`else
  // Winner select: D always wins a tie
  always_comb begin
    req_any = I_ARVALID | D_ARVALID;
    win     = D_ARVALID;
  end
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; RLAST alone ends a burst, beats are not counted
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_any) state_d = S_ADDR;
      S_ADDR:  if (M_AXI_ARREADY) state_d = S_DATA;
      S_DATA:  if (M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant and request capture, taken only when leaving IDLE
  always_comb begin
    gnt_d  = gnt_q;
    addr_d = addr_q;
    len_d  = len_q;
    if (state_q == S_IDLE && req_any) begin
      gnt_d  = win;
      addr_d = win ? D_ARADDR : I_ARADDR;
      len_d  = win ? D_ARLEN  : I_ARLEN;
    end
  end

  // Latched grant/address/length registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      gnt_q  <= 1'b0;
      addr_q <= '0;
      len_q  <= '0;
    end else begin
      gnt_q  <= gnt_d;
      addr_q <= addr_d;
      len_q  <= len_d;
    end
  end

  // Output decode; RST also forces handshakes low so nothing leaks during reset
  always_comb begin
    in_addr       = (state_q == S_ADDR) && !RST;
    in_data       = (state_q == S_DATA) && !RST;
    M_AXI_ARID    = gnt_q;
    M_AXI_ARADDR  = addr_q;
    M_AXI_ARLEN   = len_q;
    M_AXI_ARSIZE  = 3'b010;
    M_AXI_ARBURST = 2'b01;
    M_AXI_ARVALID = in_addr;
    I_ARREADY     = in_addr && M_AXI_ARREADY && !gnt_q;
    D_ARREADY     = in_addr && M_AXI_ARREADY &&  gnt_q;
    M_AXI_RREADY  = in_data && (gnt_q ? D_RREADY : I_RREADY);
    I_RDATA       = M_AXI_RDATA;
    D_RDATA       = M_AXI_RDATA;
    I_RRESP       = M_AXI_RRESP;
    D_RRESP       = M_AXI_RRESP;
    I_RVALID      = in_data && !gnt_q && M_AXI_RVALID;
    D_RVALID      = in_data &&  gnt_q && M_AXI_RVALID;
    I_RLAST       = in_data && !gnt_q && M_AXI_RLAST;
    D_RLAST       = in_data &&  gnt_q && M_AXI_RLAST;
  end

endmodule

// File: tb/tb_fmrv32im_rd_arb.sv
// Directed bench for fmrv32im_rd_arb. Expected grant order follows the
// FMRV32IM_RD_ARB_RR_EN macro when it is defined for the build.
`timescale 1ns/1ps
module tb_fmrv32im_rd_arb;

  logic        CLK, RST;
  logic [31:0] I_ARADDR, D_ARADDR, M_AXI_ARADDR;
  logic [7:0]  I_ARLEN, D_ARLEN, M_AXI_ARLEN;
  logic        I_ARVALID, D_ARVALID, I_ARREADY, D_ARREADY;
  logic [31:0] I_RDATA, D_RDATA, M_AXI_RDATA;
  logic [1:0]  I_RRESP, D_RRESP, M_AXI_RRESP;
  logic        I_RLAST, D_RLAST, I_RVALID, D_RVALID, I_RREADY, D_RREADY;
  logic        M_AXI_ARID, M_AXI_ARVALID, M_AXI_ARREADY;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_RID, M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

  int errors = 0;
  int checks = 0;

  fmrv32im_rd_arb #(.ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .I_ARADDR(I_ARADDR), .I_ARLEN(I_ARLEN), .I_ARVALID(I_ARVALID), .I_ARREADY(I_ARREADY),
    .I_RDATA(I_RDATA), .I_RRESP(I_RRESP), .I_RLAST(I_RLAST), .I_RVALID(I_RVALID), .I_RREADY(I_RREADY),
    .D_ARADDR(D_ARADDR), .D_ARLEN(D_ARLEN), .D_ARVALID(D_ARVALID), .D_ARREADY(D_ARREADY),
    .D_RDATA(D_RDATA), .D_RRESP(D_RRESP), .D_RLAST(D_RLAST), .D_RVALID(D_RVALID), .D_RREADY(D_RREADY),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive n beats to the requester selected by d (0=I, 1=D) with its RREADY high.
  // Entered one cycle into DATA; returns after the last-beat edge.
  task automatic burst(input bit d, input int n, input logic [31:0] base, input logic [1:0] resp);
    for (int k = 0; k < n; k++) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = base + k;
      M_AXI_RRESP  = resp;
      M_AXI_RLAST  = (k == n - 1);
      M_AXI_RID    = d;
      I_RREADY     = !d;
      D_RREADY     = d;
      #1;
      chk("rvalid_win",  d ? D_RVALID : I_RVALID, 1'b1);
      chk("rdata_win",   d ? D_RDATA  : I_RDATA,  base + k);
      chk("rresp_win",   d ? D_RRESP  : I_RRESP,  resp);
      chk("rlast_win",   d ? D_RLAST  : I_RLAST,  (k == n - 1));
      chk("rvalid_lose", d ? I_RVALID : D_RVALID, 1'b0);
      chk("rlast_lose",  d ? I_RLAST  : D_RLAST,  1'b0);
      chk("m_rready",    M_AXI_RREADY, 1'b1);
      step();
    end
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;
    I_RREADY     = 1'b0;
    D_RREADY     = 1'b0;
  endtask

  initial begin
    int pulses;
    int k;
    int rcv;
    bit done;
    bit exp_gnt;

    RST = 1'b1;
    I_ARADDR = '0; I_ARLEN = '0; I_ARVALID = 1'b0; I_RREADY = 1'b0;
    D_ARADDR = '0; D_ARLEN = '0; D_ARVALID = 1'b0; D_RREADY = 1'b0;
    M_AXI_ARREADY = 1'b0; M_AXI_RID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = '0;
    M_AXI_RLAST = 1'b0; M_AXI_RVALID = 1'b0;

    // ---- reset state ----
    step();
    step();
    #1;
    chk("rst_arvalid", M_AXI_ARVALID, 1'b0);
    chk("rst_iarready", I_ARREADY, 1'b0);
    chk("rst_darready", D_ARREADY, 1'b0);
    chk("rst_rready", M_AXI_RREADY, 1'b0);
    chk("rst_irvalid", I_RVALID, 1'b0);
    chk("rst_drvalid", D_RVALID, 1'b0);
    chk("rst_araddr", M_AXI_ARADDR, 32'h0);
    chk("rst_arlen", M_AXI_ARLEN, 8'h0);
    chk("rst_arid", M_AXI_ARID, 1'b0);
    chk("arsize", M_AXI_ARSIZE, 3'b010);
    chk("arburst", M_AXI_ARBURST, 2'b01);
    RST = 1'b0;
    step();

    // ---- single I burst, ARLEN 3, slave ready at once ----
    I_ARADDR = 32'h0000_0100; I_ARLEN = 8'd3; I_ARVALID = 1'b1; M_AXI_ARREADY = 1'b1;
    #1;
    chk("t1_arvalid_idle", M_AXI_ARVALID, 1'b0);
    step();
    chk("t1_arvalid", M_AXI_ARVALID, 1'b1);
    chk("t1_araddr", M_AXI_ARADDR, 32'h0000_0100);
    chk("t1_arlen", M_AXI_ARLEN, 8'd3);
    chk("t1_arid", M_AXI_ARID, 1'b0);
    chk("t1_iarready", I_ARREADY, 1'b1);
    chk("t1_darready", D_ARREADY, 1'b0);
    step();
    I_ARVALID = 1'b0;
    #1;
    chk("t1_arvalid_data", M_AXI_ARVALID, 1'b0);
    chk("t1_iarready_data", I_ARREADY, 1'b0);
    burst(1'b0, 4, 32'hA000_0000, 2'b00);
    #1;
    chk("t1_idle_rready", M_AXI_RREADY, 1'b0);
    chk("t1_idle_arvalid", M_AXI_ARVALID, 1'b0);

    // ---- simultaneous requests, four rounds from a fresh pointer ----
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int r = 0; r < 4; r++) begin
`ifdef FMRV32IM_RD_ARB_RR_EN
      exp_gnt = (r % 2) == 1;
`else
      exp_gnt = 1'b1;
`endif
      I_ARADDR = 32'h200 + r; I_ARLEN = 8'd0; I_ARVALID = 1'b1;
      D_ARADDR = 32'h300 + r; D_ARLEN = 8'd0; D_ARVALID = 1'b1;
      step();
      chk("t2_arid", M_AXI_ARID, exp_gnt);
      chk("t2_araddr", M_AXI_ARADDR, exp_gnt ? 32'h300 + r : 32'h200 + r);
      chk("t2_win_arready", exp_gnt ? D_ARREADY : I_ARREADY, 1'b1);
      chk("t2_lose_arready", exp_gnt ? I_ARREADY : D_ARREADY, 1'b0);
      step();
      I_ARVALID = 1'b0; D_ARVALID = 1'b0;
      burst(exp_gnt, 1, 32'h5000_0000 + r, 2'b00);
    end

    // ---- D single-beat burst with SLVERR ----
    D_ARADDR = 32'h0000_0400; D_ARLEN = 8'd0; D_ARVALID = 1'b1;
    step();
    chk("t3_arid", M_AXI_ARID, 1'b1);
    chk("t3_arlen", M_AXI_ARLEN, 8'd0);
    step();
    D_ARVALID = 1'b0;
    burst(1'b1, 1, 32'h0000_DEAD, 2'b10);
    #1;
    chk("t3_idle_rready", M_AXI_RREADY, 1'b0);

    // ---- ARREADY stall for 5 cycles, with I waiting ----
    M_AXI_ARREADY = 1'b0;
    D_ARADDR = 32'h0000_4440; D_ARLEN = 8'd7; D_ARVALID = 1'b1;
    #1;
    chk("t4_arvalid_idle", M_AXI_ARVALID, 1'b0);
    pulses = 0;
    step();
    for (int c = 0; c < 5; c++) begin
      I_ARVALID = 1'b1; I_ARADDR = 32'hFFFF_0000 + c; I_ARLEN = 8'hFF;
      #1;
      chk("t4_arvalid", M_AXI_ARVALID, 1'b1);
      chk("t4_araddr", M_AXI_ARADDR, 32'h0000_4440);
      chk("t4_arlen", M_AXI_ARLEN, 8'd7);
      chk("t4_iarready_wait", I_ARREADY, 1'b0);
      if (D_ARREADY) pulses++;
      step();
    end
    M_AXI_ARREADY = 1'b1;
    #1;
    chk("t4_darready_hs", D_ARREADY, 1'b1);
    chk("t4_iarready_hs", I_ARREADY, 1'b0);
    if (D_ARREADY) pulses++;
    step();
    D_ARVALID = 1'b0; I_ARVALID = 1'b0; M_AXI_ARREADY = 1'b0;
    #1;
    chk("t4_darready_data", D_ARREADY, 1'b0);
    chk("t4_arvalid_data", M_AXI_ARVALID, 1'b0);
    if (D_ARREADY) pulses++;
    chk("t4_pulses", pulses, 1);
    burst(1'b1, 8, 32'hB000_0000, 2'b00);

    // ---- RREADY backpressure, I_RREADY toggling ----
    M_AXI_ARREADY = 1'b1;
    I_ARADDR = 32'h0000_0600; I_ARLEN = 8'd7; I_ARVALID = 1'b1;
    step();
    step();
    I_ARVALID = 1'b0;
    k = 0; rcv = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = 32'hC000_0000 + k;
      M_AXI_RLAST  = (k == 7);
      I_RREADY     = (c % 2) == 1;
      #1;
      chk("t5_rready_mirror", M_AXI_RREADY, I_RREADY);
      chk("t5_irvalid", I_RVALID, 1'b1);
      if (I_RREADY) begin
        chk("t5_rdata", I_RDATA, 32'hC000_0000 + rcv);
        rcv++;
        if (k == 7) done = 1'b1;
        k++;
      end
      step();
    end
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; I_RREADY = 1'b0;
    #1;
    chk("t5_beats", rcv, 8);
    chk("t5_idle_rready", M_AXI_RREADY, 1'b0);

    // ---- reset at beat 2 of an 8-beat I burst ----
    I_ARADDR = 32'h0000_0800; I_ARLEN = 8'd7; I_ARVALID = 1'b1;
    step();
    step();
    I_ARVALID = 1'b0;
    for (int b = 0; b < 2; b++) begin
      M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'hD000_0000 + b; M_AXI_RLAST = 1'b0; I_RREADY = 1'b1;
      #1;
      chk("t6_pre_rdata", I_RDATA, 32'hD000_0000 + b);
      chk("t6_pre_rvalid", I_RVALID, 1'b1);
      step();
    end
    M_AXI_RDATA = 32'hD000_0002; RST = 1'b1;
    #1;
    chk("t6_rst_irvalid", I_RVALID, 1'b0);
    chk("t6_rst_rready", M_AXI_RREADY, 1'b0);
    step();
    RST = 1'b0; M_AXI_RVALID = 1'b0; I_RREADY = 1'b0;
    #1;
    chk("t6_post_arvalid", M_AXI_ARVALID, 1'b0);
    chk("t6_post_rready", M_AXI_RREADY, 1'b0);
    chk("t6_post_irvalid", I_RVALID, 1'b0);
    chk("t6_post_drvalid", D_RVALID, 1'b0);
    chk("t6_post_iarready", I_ARREADY, 1'b0);
    chk("t6_post_darready", D_ARREADY, 1'b0);
    chk("t6_post_araddr", M_AXI_ARADDR, 32'h0);
    D_ARADDR = 32'h0000_0900; D_ARLEN = 8'd1; D_ARVALID = 1'b1;
    #1;
    chk("t6_d_idle", M_AXI_ARVALID, 1'b0);
    step();
    chk("t6_d_arvalid", M_AXI_ARVALID, 1'b1);
    chk("t6_d_arid", M_AXI_ARID, 1'b1);
    chk("t6_d_araddr", M_AXI_ARADDR, 32'h0000_0900);
    chk("t6_d_darready", D_ARREADY, 1'b1);
    step();
    D_ARVALID = 1'b0;
    burst(1'b1, 2, 32'hE000_0000, 2'b00);
    #1;
    chk("t6_end_rready", M_AXI_RREADY, 1'b0);
    chk("t6_end_arvalid", M_AXI_ARVALID, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
